// File: rtl/lidar_frame_parser.sv
// rtl/lidar_frame_parser.sv - TF-series LiDAR 9-byte range frame parser with checksum, timeout and counters
module lidar_frame_parser #(
  parameter logic [7:0] HEADER_BYTE    = 8'h59,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] dist_o,
  output logic [15:0] strength_o,
  output logic [15:0] temp_o,
  output logic        frame_valid_o,
  output logic        csum_err_o,
  output logic        timeout_o,
  output logic [15:0] frame_count_o,
  output logic [7:0]  err_count_o,
  output logic        busy_o
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    HDR1    = 2'd0,
    HDR2    = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          timeout_hit;
  logic [2:0]    idx_q;
  logic [7:0]    sum_q;
  logic [47:0]   shadow_q;   // payload bytes shift in from the top; byte 0 ends at [7:0]
  logic [TW-1:0] tmo_q;
  logic [15:0]   dist_q, strength_q, temp_q;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [7:0]    err_count_q;
  logic          frame_valid_q, csum_err_q, timeout_q;
  logic          csum_ok;

  assign csum_ok = (rx_data == sum_q);

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= HDR1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a byte arriving on the expiry cycle suppresses the timeout
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      HDR1:    if (rx_valid && rx_data == HEADER_BYTE) state_d = HDR2;
      HDR2:    if (rx_valid) state_d = (rx_data == HEADER_BYTE) ? PAYLOAD : HDR1;
      PAYLOAD: if (rx_valid && idx_q == 3'd5) state_d = CSUM;
      CSUM:    if (rx_valid) state_d = HDR1;
      default: state_d = HDR1;
    endcase
    if (!rx_valid && state_q != HDR1 && tmo_q == TMO_LAST) begin
      state_d     = HDR1;
      timeout_hit = 1'b1;
    end
  end

  // Output logic from state
  always_comb begin
    busy_o = (state_q != HDR1);
  end

  // Good-frame counter next value, wraps naturally at 16 bits
  always_comb begin
    frame_count_d = frame_count_q;
    if (rx_valid && state_q == CSUM && csum_ok) frame_count_d = frame_count_q + 16'd1;
  end

  // Datapath: byte capture, running sum, timeout counter, result registers and strobes
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx_q         <= '0;
      sum_q         <= '0;
      shadow_q      <= '0;
      tmo_q         <= '0;
      dist_q        <= '0;
      strength_q    <= '0;
      temp_q        <= '0;
      frame_count_q <= '0;
      err_count_q   <= '0;
      frame_valid_q <= 1'b0;
      csum_err_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      csum_err_q    <= 1'b0;
      timeout_q     <= timeout_hit;
      frame_count_q <= frame_count_d;

      if (rx_valid || state_d == HDR1) begin
        tmo_q <= '0;
      end else if (state_q != HDR1) begin
        tmo_q <= tmo_q + TW'(1);
      end

      if (rx_valid) begin
        case (state_q)
          HDR1: begin
            sum_q <= rx_data;
            idx_q <= '0;
          end
          HDR2: begin
            sum_q <= sum_q + rx_data;
          end
          PAYLOAD: begin
            shadow_q <= {rx_data, shadow_q[47:8]};
            sum_q    <= sum_q + rx_data;
            idx_q    <= idx_q + 3'd1;
          end
          CSUM: begin
            if (csum_ok) begin
              dist_q        <= shadow_q[15:0];
              strength_q    <= shadow_q[31:16];
              temp_q        <= shadow_q[47:32];
              frame_valid_q <= 1'b1;
            end else begin
              if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
              csum_err_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dist_o        = dist_q;
  assign strength_o    = strength_q;
  assign temp_o        = temp_q;
  assign frame_valid_o = frame_valid_q;
  assign csum_err_o    = csum_err_q;
  assign timeout_o     = timeout_q;
  assign frame_count_o = frame_count_q;
  assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_lidar_frame_parser.sv
// tb/tb_lidar_frame_parser.sv - directed self-checking bench for lidar_frame_parser
module tb_lidar_frame_parser;

  localparam int T = 64;
  localparam logic [71:0] GOOD = 72'h5959_2C01_E803_0009_D3;
  localparam logic [71:0] BAD  = 72'h5959_2C01_E803_0009_D4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] dist_o, strength_o, temp_o, frame_count_o;
  logic        frame_valid_o, csum_err_o, timeout_o, busy_o;
  logic [7:0]  err_count_o;

  int n_vec = 0;
  int n_bad = 0;
  int n_fv = 0, n_ce = 0, n_to = 0;

  lidar_frame_parser #(.HEADER_BYTE(8'h59), .TIMEOUT_CYCLES(T)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .dist_o(dist_o), .strength_o(strength_o), .temp_o(temp_o),
    .frame_valid_o(frame_valid_o), .csum_err_o(csum_err_o), .timeout_o(timeout_o),
    .frame_count_o(frame_count_o), .err_count_o(err_count_o), .busy_o(busy_o)
  );

  always #5 clk_in = ~clk_in;

  // Count strobes away from the active edge
  always @(negedge clk_in) begin
    if (frame_valid_o) n_fv++;
    if (csum_err_o) n_ce++;
    if (timeout_o) n_to++;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_in);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [71:0] fr, input int gap);
    for (int i = 0; i < 9; i++) begin
      send_byte(fr[71-8*i -: 8]);
      if (gap > 0 && i < 8) idle(gap);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    idle(3);
    rst_in = 1'b0;
    idle(1);
    chk16("reset_dist", dist_o, 16'h0);
    chk16("reset_strength", strength_o, 16'h0);
    chk16("reset_temp", temp_o, 16'h0);
    chk16("reset_fcount", frame_count_o, 16'h0);
    chk16("reset_ecount", {8'h0, err_count_o}, 16'h0);
    chk16("reset_strobes_busy", {12'h0, frame_valid_o, csum_err_o, timeout_o, busy_o}, 16'h0);
  endtask

  task automatic test_good_frame;
    int fv0 = n_fv;
    send_frame(GOOD, 0);
    idle(2);
    chk_int("good_fv_pulses", n_fv - fv0, 1);
    chk16("good_dist", dist_o, 16'd300);
    chk16("good_strength", strength_o, 16'd1000);
    chk16("good_temp", temp_o, 16'h0900);
    chk16("good_fcount", frame_count_o, 16'd1);
    chk16("good_ecount", {8'h0, err_count_o}, 16'd0);
    chk16("good_busy", {15'h0, busy_o}, 16'd0);
  endtask

  task automatic test_bad_csum;
    int ce0 = n_ce;
    int fv0 = n_fv;
    send_frame(BAD, 0);
    idle(2);
    chk_int("bad_ce_pulses", n_ce - ce0, 1);
    chk_int("bad_fv_pulses", n_fv - fv0, 0);
    chk16("bad_ecount", {8'h0, err_count_o}, 16'd1);
    chk16("bad_dist_hold", dist_o, 16'd300);
    chk16("bad_fcount_hold", frame_count_o, 16'd1);
    send_frame(GOOD, 0);
    idle(2);
    chk16("after_bad_fcount", frame_count_o, 16'd2);
  endtask

  task automatic test_resync;
    int fv0 = n_fv;
    int ce0 = n_ce;
    send_byte(8'h00); send_byte(8'h59); send_byte(8'h12);
    send_byte(8'h59); send_byte(8'h59);
    send_byte(8'h2C); send_byte(8'h01); send_byte(8'hE8); send_byte(8'h03);
    send_byte(8'h00); send_byte(8'h09); send_byte(8'hD3);
    idle(2);
    chk_int("resync_fv_pulses", n_fv - fv0, 1);
    chk_int("resync_ce_pulses", n_ce - ce0, 0);
    chk16("resync_fcount", frame_count_o, 16'd3);
  endtask

  task automatic test_timeout;
    int to0 = n_to;
    int fv0 = n_fv;
    int waited = 0;
    send_byte(8'h59); send_byte(8'h59); send_byte(8'h2C); send_byte(8'h01);
    chk16("tmo_busy_mid", {15'h0, busy_o}, 16'd1);
    while (n_to == to0 && waited < T + 10) begin
      @(negedge clk_in);
      waited++;
    end
    idle(2);
    chk_int("tmo_pulses", n_to - to0, 1);
    chk16("tmo_busy_after", {15'h0, busy_o}, 16'd0);
    chk16("tmo_fcount_hold", frame_count_o, 16'd3);
    // A byte landing exactly on the expiry cycle keeps the frame alive
    to0 = n_to;
    send_frame(GOOD, T - 1);
    idle(2);
    chk_int("edge_tmo_pulses", n_to - to0, 0);
    chk_int("edge_fv_pulses", n_fv - fv0, 1);
    chk16("edge_fcount", frame_count_o, 16'd4);
  endtask

  task automatic test_reset_mid;
    int fv0 = n_fv;
    send_byte(8'h59); send_byte(8'h59); send_byte(8'h2C); send_byte(8'h01); send_byte(8'hE8);
    rst_in = 1'b1;
    idle(2);
    rst_in = 1'b0;
    idle(1);
    chk_int("rstmid_no_strobe", n_fv - fv0, 0);
    chk16("rstmid_dist", dist_o, 16'd0);
    chk16("rstmid_fcount", frame_count_o, 16'd0);
    chk16("rstmid_ecount_busy", {7'h0, err_count_o, busy_o}, 16'd0);
    send_frame(GOOD, 0);
    idle(2);
    chk_int("rstmid_fv_after", n_fv - fv0, 1);
    chk16("rstmid_fcount_after", frame_count_o, 16'd1);
    chk16("rstmid_dist_after", dist_o, 16'd300);
  endtask

  task automatic test_back_to_back;
    int ce0 = n_ce;
    int fv0 = n_fv;
    for (int k = 0; k < 256; k++) send_frame(BAD, 0);
    idle(2);
    chk_int("b2b_ce_pulses", n_ce - ce0, 256);
    chk16("b2b_ecount_sat", {8'h0, err_count_o}, 16'h00FF);
    send_frame(GOOD, 0);
    send_frame(GOOD, 0);
    idle(2);
    chk_int("b2b_good_pulses", n_fv - fv0, 2);
    chk16("b2b_fcount", frame_count_o, 16'd3);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk_in);
    release dut.frame_count_q;
    @(negedge clk_in);
    chk16("wrap_preload", frame_count_o, 16'hFFFF);
    send_frame(GOOD, 0);
    idle(2);
    chk16("wrap_fcount", frame_count_o, 16'h0000);
    chk16("wrap_ecount_hold", {8'h0, err_count_o}, 16'h00FF);
  endtask

  initial begin
    idle(1);
    test_reset;
    test_good_frame;
    test_bad_csum;
    test_resync;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
